// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with load, saturate mode and cascade outputs.
// State updates on the falling edge of clk; reset is synchronous.
module mod_n_counter #(
   parameter int WIDTH   = 3,
   parameter int MODULUS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             sat,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

   if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("mod_n_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end

   logic at_top;
   logic at_bot;
   logic at_bnd;

   assign at_top = (out == MAXV);
   assign at_bot = (out == '0);
   assign at_bnd = up ? at_top : at_bot;
   assign tc     = en & at_bnd;

   // Wrap targets are explicit so MODULUS == 2**WIDTH needs no overflow
   always_ff @(negedge clk) begin
      if (rst) begin
         out  <= '0;
         wrap <= 1'b0;
      end else if (load) begin
         out  <= (load_val > MAXV) ? MAXV : load_val;
         wrap <= 1'b0;
      end else if (en) begin
         wrap <= at_bnd & ~sat;
         if (at_bnd) begin
            if (!sat)
               out <= up ? '0 : MAXV;
         end else begin
            out <= up ? out + WIDTH'(1) : out - WIDTH'(1);
         end
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mod_n_counter.sv
// Scoreboard bench for mod_n_counter: random and directed stimulus
// checked against an arithmetic reference model, plus cascade/default checks.
module tb_mod_n_counter;

   localparam int M = 10;

   typedef struct {
      logic [3:0] o;
      logic       w;
      logic       t;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_val = '0;
   logic       sat = 1'b0;
   logic [3:0] out;
   logic       tc;
   logic       wrap;

   logic       c_rst = 1'b1;
   logic       c_en = 1'b0;
   logic [3:0] lo_out, hi_out;
   logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

   logic       d_rst = 1'b1;
   logic       d_en = 1'b0;
   logic [2:0] d_out;
   logic       d_tc, d_wrap;

   int m_out = 0;

   always #5 clk = ~clk;

   mod_n_counter #(.WIDTH(4), .MODULUS(M)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_val(load_val), .sat(sat), .out(out), .tc(tc), .wrap(wrap)
   );

   mod_n_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
      .clk(clk), .rst(c_rst), .en(c_en), .up(1'b1), .load(1'b0),
      .load_val(4'd0), .sat(1'b0), .out(lo_out), .tc(lo_tc), .wrap(lo_wrap)
   );

   mod_n_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
      .clk(clk), .rst(c_rst), .en(lo_tc), .up(1'b1), .load(1'b0),
      .load_val(4'd0), .sat(1'b0), .out(hi_out), .tc(hi_tc), .wrap(hi_wrap)
   );

   mod_n_counter u_def (
      .clk(clk), .rst(d_rst), .en(d_en), .up(1'b1), .load(1'b0),
      .load_val(3'd0), .sat(1'b0), .out(d_out), .tc(d_tc), .wrap(d_wrap)
   );

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Drive one cycle of inputs and push the model's post-edge view
   task automatic step(input logic r, input logic ld, input int lv,
                       input logic e, input logic u, input logic s);
      exp_t x;
      int w;
      @(posedge clk);
      #1;
      rst = r; load = ld; load_val = 4'(lv); en = e; up = u; sat = s;
      w = 0;
      if (r) m_out = 0;
      else if (ld) m_out = (lv >= M) ? M - 1 : lv;
      else if (e) begin
         if (s) m_out = u ? ((m_out + 1 > M - 1) ? M - 1 : m_out + 1)
                          : ((m_out - 1 < 0) ? 0 : m_out - 1);
         else begin
            m_out = (m_out + (u ? 1 : M - 1)) % M;
            w = u ? (m_out == 0) : (m_out == M - 1);
         end
      end
      x.o = 4'(m_out);
      x.w = w[0];
      x.t = e & (u ? (m_out == M - 1) : (m_out == 0));
      q.push_back(x);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         if (q.size() > 0) begin
            x = q.pop_front();
            chk("out", int'(out), int'(x.o));
            chk("wrap", int'(wrap), int'(x.w));
            chk("tc", int'(tc), int'(x.t));
         end
      end
   end

   initial begin : stim
      repeat (3) step(1, 0, 0, 0, 1, 0);
      repeat (12) step(0, 0, 0, 1, 1, 0);
      step(0, 1, 2, 0, 0, 0);
      repeat (4) step(0, 0, 0, 1, 0, 0);
      step(0, 1, 8, 0, 1, 1);
      repeat (3) step(0, 0, 0, 1, 1, 1);
      step(0, 1, 1, 0, 0, 1);
      repeat (3) step(0, 0, 0, 1, 0, 1);
      step(0, 1, 13, 0, 1, 0);
      step(0, 1, 4, 1, 1, 0);
      repeat (5) step(0, 0, 0, 0, 1, 0);
      step(0, 1, 9, 0, 1, 0);
      step(1, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 15), $urandom_range(0, 3) != 0,
              $urandom_range(0, 1), $urandom_range(0, 4) == 0);
      end
      step(0, 0, 0, 0, 1, 0);
      repeat (3) @(posedge clk);
      chk("scoreboard_drained", q.size(), 0);

      @(posedge clk);
      #1;
      c_rst = 1'b1; d_rst = 1'b1;
      repeat (2) @(posedge clk);
      chk("def_reset", int'(d_out), 0);
      #1;
      c_rst = 1'b0; d_rst = 1'b0; c_en = 1'b1; d_en = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(posedge clk);
         if (k <= 9) chk("def_seq", int'(d_out), k % 8);
      end
      chk("cascade_25", int'(hi_out) * 10 + int'(lo_out), 25);
      #1;
      c_en = 1'b0; d_en = 1'b0;
      @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

endmodule
